// File: rtl/calc_sequencer_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
// Includes FSM states, operator codes and the largest displayable magnitude.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  // Returns 10^digits - 1, the largest value that fits in the digit budget.
  function automatic longint unsigned max_operand(input int unsigned digits);
    longint unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad-decoder inputs and display-driver outputs of the calculator sequencer.
// The sequencer uses the slave side; whatever drives the keys uses the master side.
interface calc_sequencer_if #(parameter int RES_W = 28);
  logic             btn_press;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [RES_W-1:0] disp_val;
  logic             disp_neg;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output btn_press, is_num, is_op, is_eq, num_val, op_val,
    input  disp_val, disp_neg, ovf, busy, done
  );

  modport slave (
    input  btn_press, is_num, is_op, is_eq, num_val, op_val,
    output disp_val, disp_neg, ovf, busy, done
  );
endinterface

// File: rtl/calc_sequencer_mul.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// The first iteration runs on the start edge, so valid pulses WIDTH cycles after start.
module calc_mul #(
  parameter int WIDTH = 14,
  parameter int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [RES_W-1:0] prod,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    if (start) begin
      acc_d    = b[0] ? RES_W'(a) : '0;
      mcand_d  = RES_W'(a) << 1;
      mplier_d = b >> 1;
      cnt_d    = CNT_W'(WIDTH - 1);
      valid_d  = (WIDTH == 1);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      valid_d  = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign prod  = acc_q;
  assign valid = valid_q;

endmodule

// File: rtl/calc_sequencer.sv
// Turns keypad press levels into a two-operand add/sub/mul transaction and
// holds the sign-magnitude result for the display driver.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14,
  parameter int RES_W  = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  calc_sequencer_if.slave   kp
);

  localparam int               CNT_W   = $clog2(DIGITS + 1);
  localparam logic [RES_W-1:0] MAX_MAG = RES_W'(max_operand(DIGITS));

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             neg_q, neg_d, ovf_q, ovf_d, done_q, done_d;
  logic             btn_q, mul_start_q, mul_start_d;
  logic             key_evt;
  logic [RES_W-1:0] sum, diff, mul_prod;
  logic             mul_valid;

  assign key_evt = kp.btn_press & ~btn_q;
  assign sum     = RES_W'(a_q) + RES_W'(b_q);
  assign diff    = (a_q >= b_q) ? RES_W'(a_q - b_q) : RES_W'(b_q - a_q);

  calc_mul #(.WIDTH(WIDTH), .RES_W(RES_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start_q),
    .a     (a_q),
    .b     (b_q),
    .prod  (mul_prod),
    .valid (mul_valid)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    res_d       = res_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    mul_start_d = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (key_evt && kp.is_num) begin
          if (cnt_a_q < CNT_W'(DIGITS)) begin
            a_d     = a_q * WIDTH'(10) + WIDTH'(kp.num_val);
            cnt_a_d = cnt_a_q + CNT_W'(1);
          end
        end else if (key_evt && kp.is_op && kp.op_val != 2'd0) begin
          op_d    = op_t'(kp.op_val);
          state_d = ENTER_B;
        end else if (key_evt && kp.is_eq) begin
          res_d   = RES_W'(a_q);
          neg_d   = 1'b0;
          ovf_d   = RES_W'(a_q) > MAX_MAG;
          done_d  = 1'b1;
          state_d = SHOW;
        end
      end
      ENTER_B: begin
        if (key_evt && kp.is_num) begin
          if (cnt_b_q < CNT_W'(DIGITS)) begin
            b_d     = b_q * WIDTH'(10) + WIDTH'(kp.num_val);
            cnt_b_d = cnt_b_q + CNT_W'(1);
          end
        end else if (key_evt && kp.is_op) begin
          if (cnt_b_q == '0 && kp.op_val != 2'd0) begin
            op_d = op_t'(kp.op_val);
          end
        end else if (key_evt && kp.is_eq) begin
          mul_start_d = (op_q == OP_MUL);
          state_d     = CALC;
        end
      end
      CALC: begin
        // Key events are deliberately dropped here; only completion matters.
        if (op_q == OP_MUL) begin
          if (mul_valid) begin
            res_d   = mul_prod;
            neg_d   = 1'b0;
            ovf_d   = mul_prod > MAX_MAG;
            done_d  = 1'b1;
            state_d = SHOW;
          end
        end else if (op_q == OP_SUB) begin
          res_d   = diff;
          neg_d   = (a_q < b_q);
          ovf_d   = diff > MAX_MAG;
          done_d  = 1'b1;
          state_d = SHOW;
        end else begin
          res_d   = sum;
          neg_d   = 1'b0;
          ovf_d   = sum > MAX_MAG;
          done_d  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (key_evt && kp.is_num) begin
          a_d     = WIDTH'(kp.num_val);
          cnt_a_d = CNT_W'(1);
          b_d     = '0;
          cnt_b_d = '0;
          op_d    = OP_NONE;
          ovf_d   = 1'b0;
          neg_d   = 1'b0;
          state_d = ENTER_A;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ENTER_A;
      op_q        <= OP_NONE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      res_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      btn_q       <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      res_q       <= res_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      btn_q       <= kp.btn_press;
      mul_start_q <= mul_start_d;
    end
  end

  // Operands stay frozen during CALC, so the entry-mode mux also holds the display there.
  always_comb begin
    kp.disp_val = RES_W'(a_q);
    case (state_q)
      ENTER_A: kp.disp_val = RES_W'(a_q);
      SHOW:    kp.disp_val = res_q;
      default: kp.disp_val = (cnt_b_q != '0) ? RES_W'(b_q) : RES_W'(a_q);
    endcase
  end

  assign kp.disp_neg = (state_q == SHOW) & neg_q;
  assign kp.ovf      = ovf_q;
  assign kp.busy     = (state_q == CALC);
  assign kp.done     = done_q;

endmodule
